// File: rtl/lsu_dccm_stbuf_if.sv
// Store-buffer bus bundle: LSU store/load side in, DCCM write port and status out.
// master = LSU/DCCM-facing driver, slave = the store buffer itself.
`ifndef RV_DCCM_BITS
`define RV_DCCM_BITS 16
`endif
`ifndef RV_DCCM_FDATA_WIDTH
`define RV_DCCM_FDATA_WIDTH 39
`endif

interface lsu_dccm_stbuf_if #(
    parameter int ADDR_W = `RV_DCCM_BITS,
    parameter int DATA_W = `RV_DCCM_FDATA_WIDTH
);
    logic              st_valid;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic              st_ready;
    logic              st_commit;
    logic              st_flush;
    logic              ld_rden;
    logic [ADDR_W-1:0] ld_addr;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic              dccm_wren;
    logic [ADDR_W-1:0] dccm_wr_addr;
    logic [DATA_W-1:0] dccm_wr_data;
    logic              stbuf_empty;
    logic              stbuf_full;

    modport master (
        output st_valid, st_addr, st_data, st_commit, st_flush, ld_rden, ld_addr,
        input  st_ready, fwd_hit, fwd_data, dccm_wren, dccm_wr_addr, dccm_wr_data,
               stbuf_empty, stbuf_full
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_commit, st_flush, ld_rden, ld_addr,
        output st_ready, fwd_hit, fwd_data, dccm_wren, dccm_wr_addr, dccm_wr_data,
               stbuf_empty, stbuf_full
    );
endinterface

// File: rtl/lsu_dccm_stbuf.sv
// DCCM store buffer: allocate at DC3, commit/flush at DC4, in-order drain when no load owns the port.
// Define RV_LSU_STBUF_FWD_EN to build store-to-load forwarding; otherwise fwd outputs are tied to 0.
`ifndef RV_DCCM_BITS
`define RV_DCCM_BITS 16
`endif
`ifndef RV_DCCM_FDATA_WIDTH
`define RV_DCCM_FDATA_WIDTH 39
`endif

module lsu_dccm_stbuf #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = `RV_DCCM_BITS,
    parameter int DATA_W = `RV_DCCM_FDATA_WIDTH
) (
    input  logic           clk,
    input  logic           rst_l,
    input  logic           lsu_freeze_dc3,
    lsu_dccm_stbuf_if.slave bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t [DEPTH-1:0] mem;
    logic [PW-1:0] rd_ptr, cmt_ptr, wr_ptr;
    logic [PW-1:0] rd_nxt, cmt_nxt, wr_nxt;
    logic [PW-1:0] cnt;
    logic          full, empty, alloc, commit, flush, drain;

    // Wrap bit makes wr-rd the exact occupancy, so full and empty never alias.
    assign cnt   = wr_ptr - rd_ptr;
    assign full  = (cnt == PW'(DEPTH));
    assign empty = (cnt == '0);

    assign alloc  = bus.st_valid & ~full & ~bus.st_flush & ~lsu_freeze_dc3;
    assign commit = bus.st_commit & ~lsu_freeze_dc3 & (cmt_ptr != wr_ptr);
    assign flush  = bus.st_flush & ~lsu_freeze_dc3;
    assign drain  = (rd_ptr != cmt_ptr) & ~bus.ld_rden & ~lsu_freeze_dc3;

    assign cmt_nxt = cmt_ptr + PW'(commit);
    assign wr_nxt  = flush ? cmt_nxt : wr_ptr + PW'(alloc);
    assign rd_nxt  = rd_ptr + PW'(drain);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            rd_ptr  <= '0;
            cmt_ptr <= '0;
            wr_ptr  <= '0;
            mem     <= '0;
        end else begin
            rd_ptr  <= rd_nxt;
            cmt_ptr <= cmt_nxt;
            wr_ptr  <= wr_nxt;
            if (alloc)
                mem[wr_ptr[IW-1:0]] <= '{addr: bus.st_addr, data: bus.st_data};
        end
    end

    assign bus.st_ready     = ~full;
    assign bus.stbuf_empty  = empty;
    assign bus.stbuf_full   = full;
    assign bus.dccm_wren    = drain;
    assign bus.dccm_wr_addr = empty ? '0 : mem[rd_ptr[IW-1:0]].addr;
    assign bus.dccm_wr_data = empty ? '0 : mem[rd_ptr[IW-1:0]].data;

`ifdef RV_LSU_STBUF_FWD_EN
    // Walk oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        bus.fwd_hit  = 1'b0;
        bus.fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((PW'(i) < cnt) &&
                (mem[IW'(rd_ptr[IW-1:0] + IW'(i))].addr[ADDR_W-1:2] == bus.ld_addr[ADDR_W-1:2])) begin
                bus.fwd_hit  = 1'b1;
                bus.fwd_data = mem[IW'(rd_ptr[IW-1:0] + IW'(i))].data;
            end
        end
    end
`else
    assign bus.fwd_hit  = 1'b0;
    assign bus.fwd_data = '0;
`endif
endmodule

// File: tb/tb_lsu_dccm_stbuf.sv
// Directed bench for lsu_dccm_stbuf: queue-based reference checked every cycle plus literal spot checks.
module tb_lsu_dccm_stbuf;
    localparam int DEPTH = 4;
    localparam int AW    = 16;
    localparam int DW    = 39;

    logic clk, rst_l, frz;
    int total = 0, bad = 0;

    lsu_dccm_stbuf_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
    lsu_dccm_stbuf #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_l(rst_l), .lsu_freeze_dc3(frz), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            cmt;
    } ent_t;

    ent_t          q[$];
    logic [AW-1:0] wlog[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int ncm();
        int c = 0;
        foreach (q[i]) if (q[i].cmt) c++;
        return c;
    endfunction

    // Reference: committed entries are a prefix of q; drain pops the front.
    always @(posedge clk or negedge rst_l) begin
        if (!rst_l) q.delete();
        else begin
            int n, nc;
            bit dr, cm, fl, al;
            n  = q.size();
            nc = ncm();
            dr = (nc > 0) && !bus.ld_rden && !frz;
            cm = bus.st_commit && !frz && (nc < n);
            fl = bus.st_flush && !frz;
            al = bus.st_valid && (n < DEPTH) && !bus.st_flush && !frz;
            if (cm) q[nc].cmt = 1'b1;
            if (fl) begin
                while (q.size() > 0 && !q[q.size()-1].cmt) void'(q.pop_back());
            end else if (al) begin
                q.push_back('{bus.st_addr, bus.st_data, 1'b0});
            end
            if (dr) void'(q.pop_front());
        end
    end

    always @(negedge clk) begin
        bit            e_hit;
        logic [DW-1:0] e_fd;
        int            nc;
        nc    = ncm();
        e_hit = 1'b0;
        e_fd  = '0;
`ifdef RV_LSU_STBUF_FWD_EN
        foreach (q[i]) if (q[i].addr[AW-1:2] == bus.ld_addr[AW-1:2]) begin
            e_hit = 1'b1;
            e_fd  = q[i].data;
        end
`endif
        chk("cmp st_ready", bus.st_ready, q.size() < DEPTH);
        chk("cmp empty", bus.stbuf_empty, q.size() == 0);
        chk("cmp full", bus.stbuf_full, q.size() == DEPTH);
        chk("cmp wren", bus.dccm_wren, rst_l && nc > 0 && !bus.ld_rden && !frz);
        chk("cmp wr_addr", bus.dccm_wr_addr, q.size() > 0 ? q[0].addr : '0);
        chk("cmp wr_data", bus.dccm_wr_data, q.size() > 0 ? q[0].data : '0);
        chk("cmp fwd_hit", bus.fwd_hit, e_hit);
        chk("cmp fwd_data", bus.fwd_data, e_fd);
        if (bus.dccm_wren === 1'b1) wlog.push_back(bus.dccm_wr_addr);
    end

    task automatic clr();
        bus.st_valid  = 0; bus.st_addr = '0; bus.st_data = '0;
        bus.st_commit = 0; bus.st_flush = 0; bus.ld_rden = 0; bus.ld_addr = '0;
        frz = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.st_valid = 1; bus.st_addr = a; bus.st_data = d;
    endtask

    initial begin
        int nw;
        bit seen;
        clr();
        rst_l = 0;
        #2;
        chk("rst st_ready", bus.st_ready, 1);
        chk("rst empty", bus.stbuf_empty, 1);
        chk("rst full", bus.stbuf_full, 0);
        chk("rst wren", bus.dccm_wren, 0);
        chk("rst fwd_hit", bus.fwd_hit, 0);
        chk("rst wr_addr", bus.dccm_wr_addr, 0);
        chk("rst wr_data", bus.dccm_wr_data, 0);
        tick(); rst_l = 1; tick();

        // single store
        alloc(16'h0010, 39'hA5); tick();
        bus.st_valid = 0; bus.st_commit = 1; #1;
        chk("single uncommitted wren", bus.dccm_wren, 0);
        tick(); bus.st_commit = 0; #1;
        chk("single wren", bus.dccm_wren, 1);
        chk("single addr", bus.dccm_wr_addr, 16'h0010);
        chk("single data", bus.dccm_wr_data, 39'hA5);
        tick(); #1;
        chk("single empty after", bus.stbuf_empty, 1);

        // fill and block
        for (int i = 0; i < 4; i++) begin
            alloc(AW'(16'h20 + 4*i), DW'(i)); tick();
        end
        bus.st_valid = 0; #1;
        chk("fill full", bus.stbuf_full, 1);
        chk("fill st_ready", bus.st_ready, 0);
        alloc(16'h0030, 39'h99); tick(); bus.st_valid = 0; #1;
        chk("fill drop full", bus.stbuf_full, 1);
        bus.st_flush = 1; tick(); bus.st_flush = 0; #1;
        chk("fill flush empty", bus.stbuf_empty, 1);

        // load priority
        bus.ld_rden = 1;
        alloc(16'h0100, 39'h11); tick();
        alloc(16'h0104, 39'h22); bus.st_commit = 1; tick();
        bus.st_valid = 0; tick();
        bus.st_commit = 0;
        for (int i = 0; i < 3; i++) begin
            #1; chk("ldpri wren blocked", bus.dccm_wren, 0); tick();
        end
        nw = wlog.size();
        bus.ld_rden = 0; #1;
        chk("ldpri first wren", bus.dccm_wren, 1);
        chk("ldpri first addr", bus.dccm_wr_addr, 16'h0100);
        tick(); #1;
        chk("ldpri second wren", bus.dccm_wren, 1);
        chk("ldpri second addr", bus.dccm_wr_addr, 16'h0104);
        tick(); #1;
        chk("ldpri empty", bus.stbuf_empty, 1);
        chk("ldpri count", wlog.size(), nw + 2);
        if (wlog.size() >= nw + 2) begin
            chk("ldpri log0", wlog[nw], 16'h0100);
            chk("ldpri log1", wlog[nw+1], 16'h0104);
        end

        // flush with same-cycle commit
        bus.ld_rden = 1;
        alloc(16'h0200, 39'h1); tick();
        alloc(16'h0204, 39'h2); tick();
        alloc(16'h0208, 39'h3); bus.st_commit = 1; tick();
        bus.st_valid = 0; bus.st_flush = 1; tick();
        bus.st_flush = 0; bus.st_commit = 0; #1;
        chk("flush not empty", bus.stbuf_empty, 0);
        nw = wlog.size();
        bus.ld_rden = 0;
        tick(); tick(); tick(); #1;
        chk("flush empty", bus.stbuf_empty, 1);
        chk("flush count", wlog.size(), nw + 2);
        if (wlog.size() >= nw + 2) begin
            chk("flush log0", wlog[nw], 16'h0200);
            chk("flush log1", wlog[nw+1], 16'h0204);
        end
        seen = 0;
        foreach (wlog[i]) if (wlog[i] == 16'h0208) seen = 1;
        chk("flush killed never written", seen, 0);

        // wrap: streamed stores
        nw = wlog.size();
        for (int i = 0; i < 12; i++) begin
            if (i < 10) alloc(AW'(4*i), DW'(16'h100 + i));
            else bus.st_valid = 0;
            bus.st_commit = 1;
            tick();
        end
        clr();
        tick(); tick(); tick(); tick(); #1;
        chk("wrap count", wlog.size(), nw + 10);
        if (wlog.size() >= nw + 10)
            for (int i = 0; i < 10; i++) chk("wrap order", wlog[nw+i], AW'(4*i));
        chk("wrap empty", bus.stbuf_empty, 1);

        // forwarding
        bus.ld_rden = 1;
        alloc(16'h0040, 39'h1); tick();
        alloc(16'h0040, 39'h2); tick();
        bus.st_valid = 0; bus.ld_addr = 16'h0042; #1;
`ifdef RV_LSU_STBUF_FWD_EN
        chk("fwd hit", bus.fwd_hit, 1);
        chk("fwd youngest data", bus.fwd_data, 39'h2);
`else
        chk("fwd disabled hit", bus.fwd_hit, 0);
        chk("fwd disabled data", bus.fwd_data, 0);
`endif
        bus.ld_addr = 16'h0044; #1;
        chk("fwd miss", bus.fwd_hit, 0);
        bus.st_flush = 1; tick(); clr(); #1;
        chk("fwd flushed", bus.stbuf_empty, 1);

        // freeze blocks drain, alloc and commit
        alloc(16'h0300, 39'h7); tick();
        bus.st_valid = 0; bus.st_commit = 1; tick();
        frz = 1; alloc(16'h0304, 39'h8); #1;
        chk("freeze wren", bus.dccm_wren, 0);
        tick(); clr(); #1;
        chk("freeze held wren", bus.dccm_wren, 1);
        chk("freeze held addr", bus.dccm_wr_addr, 16'h0300);
        tick(); #1;
        chk("freeze no alloc", bus.stbuf_empty, 1);

        // reset mid-drain
        bus.ld_rden = 1;
        alloc(16'h0400, 39'h4); tick();
        alloc(16'h0404, 39'h5); bus.st_commit = 1; tick();
        bus.st_valid = 0; tick();
        bus.st_commit = 0; bus.ld_rden = 0; tick();
        rst_l = 0; #1;
        chk("rstmid wren", bus.dccm_wren, 0);
        chk("rstmid empty", bus.stbuf_empty, 1);
        chk("rstmid addr", bus.dccm_wr_addr, 0);
        tick(); rst_l = 1; tick(); tick(); #1;
        chk("rstmid stays empty", bus.stbuf_empty, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
